// File: rtl/psum_accumulator.sv
// psum_accumulator: accumulates PE partial sums per output pixel and
// requantizes (round-half-up, shift, saturate) to int8. Option: PSUM_RELU_EN.
module psum_accumulator #(
    parameter int PSUM_W = 25,
    parameter int ACC_W  = 32,
    parameter int SHIFT  = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PSUM_W-1:0] p_sum,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [7:0]        ofm_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  beat_cnt,
    output logic              acc_ovf
);

    localparam int EXT_W = ACC_W - PSUM_W;

    // Half of one output LSB; zero when no shift is applied.
    localparam logic signed [ACC_W:0] RND =
        ({{ACC_W{1'b0}}, 1'b1} << SHIFT) >> 1;

    localparam logic signed [ACC_W:0] MAX8 = 127;
    localparam logic signed [ACC_W:0] MIN8 = -128;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [ACC_W-1:0]        acc;
    logic [ACC_W-1:0]        psum_ext;
    logic [ACC_W-1:0]        base;
    logic [ACC_W-1:0]        sum;
    logic                    first;
    logic                    accept;
    logic                    last_acc;
    logic                    ovf;
    logic signed [ACC_W:0]   rnd_sum;
    logic signed [ACC_W:0]   rnd_val;
    logic [7:0]              sat8;
    logic [7:0]              q8;

    // Output slot state is the only control state; out_valid mirrors it.
    assign out_valid = (state == FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign last_acc  = accept && in_last;

    assign first    = (beat_cnt == '0);
    assign psum_ext = {{EXT_W{p_sum[PSUM_W-1]}}, p_sum};
    assign base     = first ? '0 : acc;
    assign sum      = base + psum_ext;

    // Signed overflow: like-signed operands giving an opposite-signed sum.
    assign ovf = (base[ACC_W-1] == psum_ext[ACC_W-1]) &&
                 (sum[ACC_W-1] != base[ACC_W-1]);

    // Rounding is done one bit wider so the half-LSB add never wraps.
    assign rnd_sum = $signed({sum[ACC_W-1], sum}) + RND;
    assign rnd_val = rnd_sum >>> SHIFT;

    // Clamp the rounded value to the int8 range, then apply optional ReLU.
    always_comb begin
        sat8 = rnd_val[7:0];
        if (rnd_val > MAX8) begin
            sat8 = 8'h7F;
        end else if (rnd_val < MIN8) begin
            sat8 = 8'h80;
        end
`ifdef PSUM_RELU_EN
        q8 = sat8[7] ? 8'h00 : sat8;
`else
        q8 = sat8;
`endif
    end

    // Output slot state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Slot fills on an accepted last beat and empties on a drain with no refill.
    always_comb begin
        state_next = state;
        unique case (state)
            EMPTY: begin
                if (last_acc) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (out_ready && !last_acc) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // Accumulator and beat counter; a last beat closes the pixel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc      <= '0;
            beat_cnt <= '0;
        end else if (accept) begin
            if (in_last) begin
                acc      <= '0;
                beat_cnt <= '0;
            end else begin
                acc      <= sum;
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
        end
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_ovf <= 1'b0;
        end else if (accept && ovf) begin
            acc_ovf <= 1'b1;
        end
    end

    // Result register; held while the slot is full and stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ofm_out <= '0;
        end else if (last_acc) begin
            ofm_out <= q8;
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// tb_psum_accumulator: directed vectors with hand-computed results
// for psum_accumulator at default parameters.
module tb_psum_accumulator;

    logic        clk;
    logic        rst_n;
    logic [24:0] p_sum;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [7:0]  ofm_out;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  beat_cnt;
    logic        acc_ovf;

    int vectors;
    int miscompares;

    psum_accumulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .p_sum     (p_sum),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .ofm_out   (ofm_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .beat_cnt  (beat_cnt),
        .acc_ovf   (acc_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    function automatic int relu(input int v);
`ifdef PSUM_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string tag,
                       input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v, input bit last);
        p_sum    = v[24:0];
        in_valid = 1'b1;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        p_sum       = '0;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        out_ready   = 1'b1;
        step();
        step();
        chk("rst_ofm", $signed(ofm_out), 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_beat_cnt", beat_cnt, 0);
        chk("rst_acc_ovf", acc_ovf, 0);
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", in_ready, 1);

        // 1000 + 2000 + 300 = 3300 -> (3300+128)>>8 = 13
        chk("cnt0", beat_cnt, 0);
        send(1000, 1'b0);
        chk("cnt1", beat_cnt, 1);
        send(2000, 1'b0);
        chk("cnt2", beat_cnt, 2);
        send(300, 1'b1);
        chk("cnt_wrap0", beat_cnt, 0);
        chk("sum3_valid", out_valid, 1);
        chk("sum3_ofm", $signed(ofm_out), 13);
        step();
        chk("drain_valid", out_valid, 0);

        // -3300 -> (-3172)>>>8 = -13
        send(-3300, 1'b1);
        chk("neg_round", $signed(ofm_out), relu(-13));

        send(100000, 1'b1);
        chk("sat_pos", $signed(ofm_out), 127);
        send(-100000, 1'b1);
        chk("sat_neg", $signed(ofm_out), relu(-128));
        step();
        chk("idle_valid", out_valid, 0);

        // Back-pressure: 5000 -> 5128>>8 = 20, then stall
        out_ready = 1'b0;
        send(5000, 1'b1);
        chk("bp_ofm", $signed(ofm_out), 20);
        chk("bp_valid", out_valid, 1);
        p_sum    = 25'd256;
        in_valid = 1'b1;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", in_ready, 0);
            step();
            chk("bp_hold", $signed(ofm_out), 20);
        end
        chk("bp_cnt", beat_cnt, 0);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("bp_reload_valid", out_valid, 1);
        chk("bp_reload_ofm", $signed(ofm_out), 1);
        step();
        chk("bp_drained", out_valid, 0);

        // 129 beats of 2^24-1 overflow a 32-bit accumulator
        for (int i = 0; i < 129; i++) begin
            send(16777215, i == 128);
            if (i == 127) begin
                chk("ovf_cnt128", beat_cnt, 128);
                chk("ovf_not_yet", acc_ovf, 0);
            end
        end
        chk("ovf_set", acc_ovf, 1);
        chk("ovf_ofm", $signed(ofm_out), relu(-128));
        send(256, 1'b1);
        chk("ovf_sticky", acc_ovf, 1);
        chk("ovf_next_ofm", $signed(ofm_out), 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("ovf_cleared", acc_ovf, 0);
        chk("ovf_rst_valid", out_valid, 0);

        // Reset mid-pixel discards partial sum
        send(1000, 1'b0);
        send(1000, 1'b0);
        chk("mid_cnt2", beat_cnt, 2);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_cnt0", beat_cnt, 0);
        send(512, 1'b0);
        send(256, 1'b1);
        chk("mid_ofm", $signed(ofm_out), 3);
        chk("mid_valid", out_valid, 1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
